// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multi-channel PWM generator.
//   CNT_W_DEF / N_CH_DEF : default counter width and channel count
//   dir_t                : counter direction (used by the center-aligned build)
//   period_cycles()      : number of clock cycles in one PWM period
package pwm_pkg;

  localparam int CNT_W_DEF = 13;
  localparam int N_CH_DEF  = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Edge-aligned periods last P+1 cycles; center-aligned periods last 2P
  // cycles, except P=0, which degenerates to the edge-aligned single cycle.
  function automatic int unsigned period_cycles(input int unsigned p, input logic center);
    if (center && (p != 0)) return 2 * p;
    else                    return p + 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One PWM output: double-buffered duty register plus comparator and output flop.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : run enable; low forces the output low
//   load         : copy shadow into active this cycle (period wrap or en low)
//   duty_we      : shadow write strobe for this channel
//   duty_in      : new duty value
//   cnt          : shared period counter
//   pwm          : registered output, (cnt < duty_active) one cycle late
//   pending      : shadow differs from active
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int              CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DUTY_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic             pending
);

  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_sh  <= DUTY_RST;
      duty_act <= DUTY_RST;
      pwm      <= 1'b0;
    end else begin
      if (duty_we) duty_sh <= duty_in;
      // A write landing on the load cycle is forwarded straight to active.
      if (load) duty_act <= duty_we ? duty_in : duty_sh;
      pwm <= en && (cnt < duty_act);
    end
  end

  assign pending = (duty_sh != duty_act);

endmodule

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen
// Multi-channel PWM generator: one shared period counter, N_CH duty comparators,
// double-buffered period and duty registers that load at the period boundary.
// Optional feature macro: PWM_CENTER_ALIGNED_EN (adds center_mode input and
// up/down counting).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   en           : run enable; low holds cnt at 0, outputs low, registers load
//   center_mode  : (PWM_CENTER_ALIGNED_EN only) up/down counting, sampled while en=0
//   period_we    : period shadow write strobe
//   period_in    : new period value P (period is P+1 cycles edge-aligned)
//   duty_we      : per-channel duty shadow write strobes
//   duty_in      : duty value for every strobed channel
//   pwm          : registered PWM outputs
//   cnt          : current counter value
//   period_end   : one-cycle pulse after the boundary cycle
//   cfg_pending  : some shadow register differs from its active copy
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int N_CH       = N_CH_DEF,
  parameter int PERIOD_RST = 4999,
  parameter int DUTY_RST   = 2500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic             center_mode,
`endif
  input  logic             period_we,
  input  logic [CNT_W-1:0] period_in,
  input  logic [N_CH-1:0]  duty_we,
  input  logic [CNT_W-1:0] duty_in,
  output logic [N_CH-1:0]  pwm,
  output logic [CNT_W-1:0] cnt,
  output logic             period_end,
  output logic             cfg_pending
);

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);
  localparam logic [CNT_W-1:0] DUTY_INIT   = CNT_W'(DUTY_RST);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] period_act;
  logic             period_end_q;
  logic             boundary;
  logic             load;
  logic [N_CH-1:0]  ch_pending;

`ifdef PWM_CENTER_ALIGNED_EN
  logic center_q;
  dir_t dir_q;
  dir_t dir_next;

  always_comb begin
    // P=0 and P=1 have no down leg, so they wrap exactly like edge-aligned.
    if (center_q && (period_act > CNT_ONE))
      boundary = en && (dir_q == DIR_DOWN) && (cnt_q == CNT_ONE);
    else
      boundary = en && (cnt_q == period_act);
  end

  always_comb begin
    cnt_next = cnt_q;
    dir_next = dir_q;
    if (!en || boundary) begin
      cnt_next = '0;
      dir_next = DIR_UP;
    end else if (dir_q == DIR_DOWN) begin
      cnt_next = cnt_q - CNT_ONE;
    end else if (center_q && (cnt_q == period_act)) begin
      cnt_next = period_act - CNT_ONE;
      dir_next = DIR_DOWN;
    end else begin
      cnt_next = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      center_q <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      if (!en) center_q <= center_mode;
      dir_q <= dir_next;
    end
  end
`else
  always_comb begin
    boundary = en && (cnt_q == period_act);
    if (!en || boundary) cnt_next = '0;
    else                 cnt_next = cnt_q + CNT_ONE;
  end
`endif

  // While disabled the active set tracks the shadows every cycle.
  assign load = !en || boundary;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      period_sh    <= PERIOD_INIT;
      period_act   <= PERIOD_INIT;
      period_end_q <= 1'b0;
    end else begin
      cnt_q <= cnt_next;
      if (period_we) period_sh <= period_in;
      if (load) period_act <= period_we ? period_in : period_sh;
      period_end_q <= boundary;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W    (CNT_W),
      .DUTY_RST (DUTY_INIT)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .duty_we (duty_we[i]),
      .duty_in (duty_in),
      .cnt     (cnt_q),
      .pwm     (pwm[i]),
      .pending (ch_pending[i])
    );
  end

  assign cnt         = cnt_q;
  assign period_end  = period_end_q;
  assign cfg_pending = (period_sh != period_act) || (|ch_pending);

endmodule
